// File: rtl/spine_router_pkg.sv
// Shared constants and state encoding for the group spine router.
// Imported by the output arbiter and its round-robin picker.
package spine_router_pkg;

  localparam int NUM_PORTS   = 11;
  localparam int IDXW        = 4;
  localparam int MAX_PKT_LEN = 16;
  localparam int CNTW        = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority picker: first set request at or above ptr_i,
// wrapping modulo N. Purely combinational.
module rr_priority_pick
  import spine_router_pkg::*;
#(
  parameter int N = NUM_PORTS,
  parameter int W = IDXW
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] pick_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Walk the ports starting at the pointer and keep the first requester.
  always_comb begin
    int p;
    logic [W-1:0] pi;
    p      = 0;
    pi     = '0;
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int k = 0; k < N; k++) begin
      p = int'(ptr_i) + k;
      if (p >= N) p = p - N;
      pi = W'(p);
      if (!any_o && req_i[pi]) begin
        any_o      = 1'b1;
        pick_o[pi] = 1'b1;
        idx_o      = pi;
      end
    end
  end

endmodule

// File: rtl/spine_output_arbiter.sv
// Per-output-port packet arbiter: round-robin grant locked for a
// whole packet, with a beat watchdog that forces release.
module spine_output_arbiter
  import spine_router_pkg::*;
#(
  parameter int NUM_PORTS   = 11,
  parameter int IDXW        = 4,
  parameter int MAX_PKT_LEN = 16,
  parameter int CNTW        = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] last,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 grant_valid,
  output logic [IDXW-1:0]      grant_idx,
  output logic                 xfer,
  output logic                 pkt_done,
  output logic                 timeout_err
);

  state_e               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IDXW-1:0]      idx_q;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]      beat_q, beat_d;
  logic                 done_q, tmo_q;

  logic [NUM_PORTS-1:0] pick;
  logic [IDXW-1:0]      pick_idx;
  logic                 pick_any;
  logic                 tail, wdog, rel;

  rr_priority_pick #(
    .N(NUM_PORTS),
    .W(IDXW)
  ) u_pick (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .pick_o(pick),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign grant_valid = (state_q == ST_LOCKED);
  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign pkt_done    = done_q;
  assign timeout_err = tmo_q;

  // Transfer, tail and watchdog conditions for the held grant.
  assign xfer = grant_valid & req[idx_q] & out_ready;
  assign tail = xfer & last[idx_q];
  assign wdog = xfer & ~last[idx_q]
              & (beat_q == CNTW'(MAX_PKT_LEN - 1));
  assign rel  = tail | wdog;

  // Pointer moves past the released input; beat counter steps.
  always_comb begin
    rr_ptr_d = (idx_q == IDXW'(NUM_PORTS - 1)) ? '0 : idx_q + 1'b1;
    beat_d   = beat_q + 1'b1;
  end

  // Arbiter FSM with counter and one-cycle status pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      done_q <= tail;
      tmo_q  <= wdog;
      case (state_q)
        ST_IDLE: begin
          if (pick_any) begin
            state_q <= ST_LOCKED;
            grant_q <= pick;
            idx_q   <= pick_idx;
            beat_q  <= '0;
          end
        end
        ST_LOCKED: begin
          if (rel) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            beat_q   <= '0;
            rr_ptr_q <= rr_ptr_d;
          end else if (xfer) begin
            beat_q <= beat_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spine_output_arbiter.sv
// Randomized scoreboard bench for spine_output_arbiter.
// Packet-level reference model predicts per-cycle outputs and transfers.
module tb_spine_output_arbiter;
  import spine_router_pkg::*;

  localparam int N    = NUM_PORTS;
  localparam int MAXL = MAX_PKT_LEN;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, last;
  logic            out_ready;
  logic [N-1:0]    grant;
  logic            grant_valid;
  logic [IDXW-1:0] grant_idx;
  logic            xfer, pkt_done, timeout_err;

  always #5 clk = ~clk;

  spine_output_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .last       (last),
    .out_ready  (out_ready),
    .grant      (grant),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .xfer       (xfer),
    .pkt_done   (pkt_done),
    .timeout_err(timeout_err)
  );

  typedef struct {
    bit gv;
    int idx;
    bit xf;
    bit done;
    bit tmo;
  } cyc_t;

  typedef struct {
    int port;
    bit tail;
  } xf_t;

  cyc_t cyc_q[$];
  xf_t  xf_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  int flits[N];
  int npk[N];
  int plen[N];
  bit nolast[N];
  bit rdy_q[$];
  bit rnd_rdy = 0;

  bit m_lock, m_done, m_tmo;
  int m_own, m_beats, m_ptr;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected cycle record and any expected transfer.
  always @(negedge clk) begin
    cyc_t c;
    xf_t  x;
    if (mon_en) begin
      chk("cyc_avail", int'(cyc_q.size() > 0), 1);
      if (cyc_q.size() > 0) begin
        c = cyc_q.pop_front();
        chk("grant_valid", int'(grant_valid), int'(c.gv));
        chk("grant_idx", int'(grant_idx), c.idx);
        chk("grant", int'(grant), c.gv ? (1 << c.idx) : 0);
        chk("xfer", int'(xfer), int'(c.xf));
        chk("pkt_done", int'(pkt_done), int'(c.done));
        chk("timeout_err", int'(timeout_err), int'(c.tmo));
      end
      if (xfer) begin
        chk("xf_avail", int'(xf_q.size() > 0), 1);
        if (xf_q.size() > 0) begin
          x = xf_q.pop_front();
          chk("xf_port", int'(grant_idx), x.port);
          chk("xf_tail", int'(last[grant_idx]), int'(x.tail));
        end
      end
    end
  end

  task automatic load(int i, int len, int cnt, bit nl);
    plen[i]   = len;
    flits[i]  = len;
    npk[i]    = cnt - 1;
    nolast[i] = nl;
  endtask

  task automatic consume(int i);
    flits[i]--;
    if (flits[i] == 0 && npk[i] > 0) begin
      npk[i]--;
      flits[i] = plen[i];
    end
  endtask

  function automatic bit busy();
    bit b;
    b = m_lock;
    for (int i = 0; i < N; i++)
      if (flits[i] > 0 || npk[i] > 0) b = 1;
    return b;
  endfunction

  task automatic model_reset();
    m_lock = 0; m_done = 0; m_tmo = 0;
    m_own = 0; m_beats = 0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      flits[i] = 0; npk[i] = 0; plen[i] = 0; nolast[i] = 0;
    end
  endtask

  // One cycle: drive sources, predict outputs, advance the model.
  task automatic step();
    cyc_t c;
    logic [N-1:0] r, l;
    bit rd;
    bit found;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      r[i] = flits[i] > 0;
      if (flits[i] > 0) l[i] = (flits[i] == 1) && !nolast[i];
      else l[i] = 1'($urandom % 2);
    end
    if (rdy_q.size() > 0) rd = rdy_q.pop_front();
    else rd = rnd_rdy ? ($urandom % 4 != 0) : 1'b1;
    req = r;
    last = l;
    out_ready = rd;
    c.gv   = m_lock;
    c.idx  = m_lock ? m_own : 0;
    c.done = m_done;
    c.tmo  = m_tmo;
    c.xf   = m_lock && r[m_own] && rd;
    m_done = 0;
    m_tmo  = 0;
    if (!m_lock) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!found && r[p]) begin
          found = 1;
          m_own = p;
        end
      end
      if (found) begin
        m_lock = 1;
        m_beats = 0;
      end
    end else if (c.xf) begin
      xf_q.push_back('{port: m_own, tail: l[m_own]});
      m_beats++;
      consume(m_own);
      if (l[m_own]) begin
        m_done = 1;
        m_lock = 0;
        m_ptr = (m_own + 1) % N;
      end else if (m_beats == MAXL) begin
        m_tmo = 1;
        m_lock = 0;
        m_ptr = (m_own + 1) % N;
      end
    end
    cyc_q.push_back(c);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    chk("drain_budget", int'(n < budget), 1);
    step();
    step();
  endtask

  initial begin
    reset = 1'b0;
    req = '0;
    last = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_grant", int'(grant), 0);
    chk("rst_valid", int'(grant_valid), 0);
    chk("rst_idx", int'(grant_idx), 0);
    chk("rst_xfer", int'(xfer), 0);
    chk("rst_pulses", int'({pkt_done, timeout_err}), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    mon_en = 1;

    repeat (5) step();

    load(3, 4, 1, 0);
    drain(100);
    load(2, 1, 1, 0);
    load(5, 1, 1, 0);
    drain(100);

    load(0, 2, 2, 0);
    load(5, 2, 1, 0);
    load(10, 2, 1, 0);
    drain(200);

    load(2, 3, 1, 0);
    rdy_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    drain(100);

    load(7, 16, 1, 1);
    load(9, 2, 1, 0);
    load(1, 2, 1, 0);
    drain(200);

    load(4, 10, 1, 0);
    repeat (4) step();
    mon_en = 0;
    #2 reset = 1'b0;
    #1;
    chk("async_grant", int'(grant), 0);
    chk("async_valid", int'(grant_valid), 0);
    chk("async_idx", int'(grant_idx), 0);
    chk("async_xfer", int'(xfer), 0);
    cyc_q.delete();
    xf_q.delete();
    rdy_q.delete();
    model_reset();
    req = '0;
    last = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    load(4, 2, 1, 0);
    load(1, 2, 1, 0);
    step();
    mon_en = 1;
    drain(100);

    rnd_rdy = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (flits[i] == 0 && npk[i] == 0 && $urandom % 16 == 0) begin
          if ($urandom % 10 == 0) load(i, 16, 1, 1);
          else load(i, $urandom_range(1, 20), $urandom_range(1, 3), 0);
        end
      end
      step();
    end
    drain(5000);

    @(negedge clk);
    #1;
    chk("xf_left", xf_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
